// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// One shift-add or restoring-subtract step per cycle, then a single sign-fix cycle.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic             is_div_q, is_div_d;
    logic             neg_a_q, neg_a_d;
    logic             neg_b_q, neg_b_d;
    logic             divz_q, divz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;
    logic               op_signed;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    assign busy = (state_q == RUN);
    assign done = (state_q == FIX) && !flush;
    assign hi   = hi_q;
    assign lo   = lo_q;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        quo_d    = quo_q;
        m_d      = m_q;
        is_div_d = is_div_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        divz_d   = divz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        mul_sum  = {1'b0, acc_q} + (quo_q[0] ? {1'b0, m_q} : {(WIDTH + 1){1'b0}});
        div_sh   = {acc_q, quo_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, m_q};
        div_ge   = (div_sh >= {1'b0, m_q});

        prod = {acc_q, quo_q};
        if (neg_a_q ^ neg_b_q) begin
            prod = -prod;
        end
        quot = (neg_a_q ^ neg_b_q) ? -quo_q : quo_q;
        // Remainder follows the dividend sign; for x/0 this reconstructs opA exactly.
        rem  = neg_a_q ? -acc_q : acc_q;

        fix_hi = is_div_q ? rem : prod[2*WIDTH-1:WIDTH];
        fix_lo = is_div_q ? (divz_q ? {WIDTH{1'b1}} : quot) : prod[WIDTH-1:0];

        op_signed = ~op[0];
        a_mag     = (op_signed && opA[WIDTH-1]) ? -opA : opA;
        b_mag     = (op_signed && opB[WIDTH-1]) ? -opB : opB;

        case (state_q)
            IDLE: ;
            RUN: begin
                if (is_div_q) begin
                    acc_d = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], div_ge};
                end else begin
                    acc_d = mul_sum[WIDTH:1];
                    quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
                end
                count_d = count_q + CW'(1);
                if (count_q == LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                hi_d    = fix_hi;
                lo_d    = fix_lo;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // busy is low outside RUN, so FIX accepts the next request too.
        if (state_q != RUN && start) begin
            case (op)
                3'd0, 3'd1, 3'd2, 3'd3: begin
                    state_d  = RUN;
                    count_d  = '0;
                    acc_d    = '0;
                    quo_d    = op[1] ? a_mag : b_mag;
                    m_d      = op[1] ? b_mag : a_mag;
                    is_div_d = op[1];
                    neg_a_d  = op_signed & opA[WIDTH-1];
                    neg_b_d  = op_signed & opB[WIDTH-1];
                    divz_d   = op[1] && (opB == '0);
                end
                3'd4:    hi_d = opA;
                3'd5:    lo_d = opA;
                default: ;
            endcase
        end

        if (flush) begin
            state_d = IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            quo_q    <= '0;
            m_q      <= '0;
            is_div_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            divz_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            quo_q    <= quo_d;
            m_q      <= m_d;
            is_div_q <= is_div_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            divz_q   <= divz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO and done cycle are queued at issue,
// a monitor pops and checks them whenever done pulses.
module tb_mult_div_unit;

    localparam int unsigned WIDTH = 32;

    logic              clock   = 1'b0;
    logic              reset_n = 1'b0;
    logic              start   = 1'b0;
    logic              flush   = 1'b0;
    logic [2:0]        op      = 3'd0;
    logic [WIDTH-1:0]  opA     = '0;
    logic [WIDTH-1:0]  opB     = '0;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  hi;
    logic [WIDTH-1:0]  lo;

    mult_div_unit #(.WIDTH(WIDTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .opA     (opA),
        .opB     (opB),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clock = ~clock;

    int checks  = 0;
    int errors  = 0;
    int results = 0;
    int cyc     = 0;

    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] hi;
        logic [WIDTH-1:0] lo;
        int               cyc;
    } exp_t;

    exp_t sb[$];
    logic [WIDTH-1:0] mhi = '0;
    logic [WIDTH-1:0] mlo = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b);
        start = 1'b1;
        op    = o;
        opA   = a;
        opB   = b;
        tick();
        start = 1'b0;
    endtask

    // Call before the edge that samples start.
    task automatic expect_res(input logic [WIDTH-1:0] h, input logic [WIDTH-1:0] l);
        exp_t e;
        e.hi  = h;
        e.lo  = l;
        e.cyc = cyc + int'(WIDTH) + 1;
        sb.push_back(e);
        mhi = h;
        mlo = l;
    endtask

    task automatic wait_results(input int n);
        for (int i = 0; i < 100 && results < n; i++) tick();
        check("wait_results", results, n);
    endtask

    // Monitor: done seen mid-cycle, HI/LO checked just after the following edge.
    initial begin
        forever begin
            exp_t e;
            @(negedge clock);
            if (reset_n && done === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 at cycle %0d, expected none",
                             cyc);
                end else begin
                    e = sb.pop_front();
                    check("done_cycle", cyc, e.cyc);
                    @(posedge clock);
                    #1;
                    check("result_hi", hi, e.hi);
                    check("result_lo", lo, e.lo);
                    results++;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        logic seen_busy;

        #12;
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset_n = 1'b1;
        tick();

        // 1: signed multiply, latency and busy width
        expect_res(32'hFFFF_FFFF, 32'hFFFF_FFFA);
        issue(3'd0, 32'hFFFF_FFFE, 32'd3);
        busy_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (done) break;
            if (busy) busy_cnt++;
        end
        check("t1_busy_cycles", busy_cnt, 32);
        wait_results(1);

        // 2: unsigned multiply, then MTHI/MTLO
        expect_res(32'hFFFF_FFFE, 32'h0000_0001);
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_results(2);
        issue(3'd4, 32'hDEAD_BEEF, 32'd0);
        check("mthi_hi", hi, 32'hDEAD_BEEF);
        check("mthi_lo", lo, 32'h0000_0001);
        check("mthi_busy", busy, 0);
        issue(3'd5, 32'hCAFE_F00D, 32'd0);
        check("mtlo_lo", lo, 32'hCAFE_F00D);
        mhi = 32'hDEAD_BEEF;
        mlo = 32'hCAFE_F00D;
        seen_busy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            seen_busy |= busy;
            tick();
        end
        check("mt_busy_never", seen_busy, 0);

        // 3: signed and unsigned divide
        expect_res(32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        wait_results(3);
        expect_res(32'd1, 32'd3);
        issue(3'd3, 32'd7, 32'd2);
        wait_results(4);

        // 4: divide by zero and MIN_INT / -1
        expect_res(32'h0000_1234, 32'hFFFF_FFFF);
        issue(3'd2, 32'h0000_1234, 32'd0);
        wait_results(5);
        expect_res(32'h0000_0000, 32'h8000_0000);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_results(6);
        expect_res(32'd5, 32'hFFFF_FFFF);
        issue(3'd3, 32'd5, 32'd0);
        wait_results(7);
        expect_res(32'hFFFF_FFF8, 32'hFFFF_FFFF);
        issue(3'd2, 32'hFFFF_FFF8, 32'd0);
        wait_results(8);

        // 5: start while busy ignored; start in FIX accepted
        expect_res(32'd2, 32'd14);
        issue(3'd2, 32'd100, 32'd7);
        repeat (4) tick();
        issue(3'd1, 32'd2, 32'd2);
        wait_results(9);
        expect_res(32'd2, 32'd14);
        issue(3'd3, 32'd100, 32'd7);
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (done) break;
        end
        expect_res(32'd0, 32'd15);
        start = 1'b1;
        op    = 3'd1;
        opA   = 32'd3;
        opB   = 32'd5;
        tick();
        start = 1'b0;
        wait_results(11);

        // 6: flush in RUN
        issue(3'd1, 32'd2, 32'd3);
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_run_busy", busy, 0);
        check("flush_run_hi", hi, mhi);
        check("flush_run_lo", lo, mlo);
        repeat (40) tick();
        check("flush_run_no_result", results, 11);

        // flush in FIX beats the HI/LO write
        issue(3'd1, 32'd5, 32'd5);
        repeat (31) tick();
        check("pre_fix_busy", busy, 1);
        tick();
        check("fix_busy", busy, 0);
        flush = 1'b1;
        #1;
        check("fix_flush_done", done, 0);
        tick();
        flush = 1'b0;
        check("flush_fix_hi", hi, mhi);
        check("flush_fix_lo", lo, mlo);
        tick();
        check("flush_fix_done_after", done, 0);

        // flush drops a start in IDLE
        start = 1'b1;
        op    = 3'd4;
        opA   = 32'h1234_5678;
        flush = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b0;
        check("flush_start_hi", hi, mhi);

        // async reset mid-operation
        issue(3'd1, 32'h0000_FFFF, 32'h0000_FFFF);
        repeat (19) tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_hi", hi, 0);
        check("async_rst_lo", lo, 0);
        check("async_rst_busy", busy, 0);
        mhi = '0;
        mlo = '0;
        #3;
        reset_n = 1'b1;
        tick();

        expect_res(32'hFFFF_FFFF, 32'hFFFF_FFEB);
        issue(3'd0, 32'd7, 32'hFFFF_FFFD);
        wait_results(12);
        check("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
